// File: rtl/code_sequencer_pkg.sv
// code_sequencer_pkg
// Shared definitions for the code sequencer: default widths of the select
// code and the dwell field, and the FSM state encoding.
package code_sequencer_pkg;

    localparam int CODE_W_DEF  = 4;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/code_sequencer_if.sv
// code_sequencer_if
// Control/status bundle between the controlling logic (master) and the
// code sequencer (slave).
//   start, stop      : sequence control
//   dir, mode        : 0/1 = up/down, one-shot/continuous
//   first, last      : code range
//   dwell            : extra hold cycles per code
//   code, code_valid : select code toward the decoder and its qualifier
//   busy, done       : status, done is a one-cycle pulse
interface code_sequencer_if
    import code_sequencer_pkg::*;
#(
    parameter int CODE_W  = CODE_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) ();

    logic               start;
    logic               stop;
    logic               dir;
    logic               mode;
    logic [CODE_W-1:0]  first;
    logic [CODE_W-1:0]  last;
    logic [DWELL_W-1:0] dwell;
    logic [CODE_W-1:0]  code;
    logic               code_valid;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, dir, mode, first, last, dwell,
        input  code, code_valid, busy, done
    );

    modport slave (
        input  start, stop, dir, mode, first, last, dwell,
        output code, code_valid, busy, done
    );

endinterface

// File: rtl/code_sequencer_dwell_timer.sv
// dwell_timer
// Loadable down-counter that times how long each code is held.
//   clk, rst : clock, asynchronous active-high reset
//   load     : load value (has priority over en)
//   value    : reload value
//   en       : decrement by one; the counter never goes below zero
//   zero     : count == 0
module dwell_timer
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] value,
    input  logic               en,
    output logic               zero
);

    logic [DWELL_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - DWELL_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/code_sequencer.sv
// code_sequencer
// Generates the 4-bit select code for the 4-to-16 decoder. Steps from first
// to last (up or down, modulo 2^CODE_W), holding each code dwell+1 cycles,
// either once (with a done pulse) or looping until stopped.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : code_sequencer_if slave (start/stop/config in, code/status out)
// code[3]=A (MSB) .. code[0]=D feed the decoder inputs directly.
module code_sequencer
    import code_sequencer_pkg::*;
#(
    parameter int CODE_W  = CODE_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    code_sequencer_if.slave bus
);

    state_t             state_reg, state_next;
    logic [CODE_W-1:0]  code_reg, code_next;
    logic [CODE_W-1:0]  first_reg, last_reg;
    logic [DWELL_W-1:0] dwell_reg;
    logic               dir_reg, mode_reg;
    logic               valid_reg, busy_reg, done_reg;

    logic               timer_load, timer_en, timer_zero;
    logic [DWELL_W-1:0] timer_value;
    logic               accept;

    // start is only honoured in IDLE; stop is not looked at there.
    assign accept = (state_reg == IDLE) && bus.start;

    // Configuration is captured once per sequence so the inputs may change
    // freely while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_reg <= '0;
            last_reg  <= '0;
            dwell_reg <= '0;
            dir_reg   <= 1'b0;
            mode_reg  <= 1'b0;
        end else if (accept) begin
            first_reg <= bus.first;
            last_reg  <= bus.last;
            dwell_reg <= bus.dwell;
            dir_reg   <= bus.dir;
            mode_reg  <= bus.mode;
        end
    end

    dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .value (timer_value),
        .en    (timer_en),
        .zero  (timer_zero)
    );

    always_comb begin
        state_next  = state_reg;
        code_next   = code_reg;
        timer_load  = 1'b0;
        timer_en    = 1'b0;
        timer_value = dwell_reg;
        case (state_reg)
            IDLE: begin
                code_next = '0;
                if (bus.start) begin
                    state_next  = RUN;
                    code_next   = bus.first;
                    timer_load  = 1'b1;
                    timer_value = bus.dwell;   // latched copy not yet valid
                end
            end
            RUN: begin
                if (bus.stop) begin
                    // Abort wins over any advance or terminal event.
                    state_next = IDLE;
                    code_next  = '0;
                end else if (!timer_zero) begin
                    timer_en = 1'b1;
                end else if (code_reg != last_reg) begin
                    code_next  = dir_reg ? code_reg - CODE_W'(1) : code_reg + CODE_W'(1);
                    timer_load = 1'b1;
                end else if (mode_reg) begin
                    code_next  = first_reg;
                    timer_load = 1'b1;
                end else begin
                    state_next = DONE;
                    code_next  = '0;
                end
            end
            DONE: begin
                state_next = IDLE;
                code_next  = '0;
            end
            default: begin
                state_next = IDLE;
                code_next  = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with state_reg and the code register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            code_reg  <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            valid_reg <= (state_next == RUN);
            busy_reg  <= (state_next == RUN);
            done_reg  <= (state_next == DONE);
        end
    end

    assign bus.code       = code_reg;
    assign bus.code_valid = valid_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;

endmodule
